axi4l_arb2: RTL and testbench
=============================

AXI4L_ARB2 -- requirements
Module: axi4l_arb2

Interface
REQ-001 Parameter: ADDR_WIDTH, default 3, byte-address width on all ports.
REQ-002 Parameter: DATA_WIDTH, fixed at 32; wstrb is DATA_WIDTH/8 bits.
REQ-003 aclk  in  1  sole clock; all logic on rising edge.
REQ-004 areset  in  1  reset: asynchronous, active-high.
REQ-005 m0_aw*/m1_aw*  in: awvalid 1, awaddr ADDR_WIDTH, awprot 3; out: awready 1.
REQ-006 m0_w*/m1_w*  in: wvalid 1, wdata 32, wstrb 4; out: wready 1.
REQ-007 m0_b*/m1_b*  out: bvalid 1, bresp 2; in: bready 1.
REQ-008 m0_ar*/m1_ar*  in: arvalid 1, araddr ADDR_WIDTH, arprot 3; out: arready 1.
REQ-009 m0_r*/m1_r*  out: rvalid 1, rdata 32, rresp 2; in: rready 1.
REQ-010 s_*  the same AXI4-Lite channel set with directions mirrored: master port toward one shared register-bank slave.

Function
REQ-011 Write path and read path SHALL be arbitrated by two independent FSMs; one master may write while the other reads.
REQ-012 Write FSM states: W_IDLE, W_XFER, W_RESP.
REQ-013 W_IDLE: if either mX_awvalid=1, latch grant and go to W_XFER next cycle.
REQ-014 Write grant SHALL ignore wvalid; grant is requested by awvalid only.
REQ-015 Write tie-break SHALL be round-robin: on simultaneous requests, grant the master not granted last; last-granted resets to m1, so m0 wins the first tie.
REQ-016 W_XFER: forward granted master's AW and W channels combinationally to s_aw*/s_w*.
REQ-017 W_XFER: per-channel done flags SHALL suppress s_awvalid after the AW handshake and s_wvalid after the W handshake.
REQ-018 W_XFER: AW and W handshakes may complete in the same cycle or in either order; go to W_RESP once both have completed.
REQ-019 W_RESP: route s_bvalid/s_bresp to the granted master and that master's bready to s_bready.
REQ-020 W_RESP: on the B handshake, return to W_IDLE, update last-granted and clear the done flags.
REQ-021 Read FSM states: R_IDLE, R_XFER, R_RESP.
REQ-022 Read FSM SHALL follow the write rules: arvalid requests the grant; separate round-robin pointer; AR forwarded in R_XFER; R routed in R_RESP; R handshake returns to R_IDLE.
REQ-023 A non-granted master SHALL see awready=wready=arready=0 and bvalid=rvalid=0; its requests stay pending and are not dropped.
REQ-024 rdata/rresp/bresp MAY be broadcast to both masters; only the valid flags are gated by grant.
REQ-025 In the idle states, all s_*valid and s_*ready outputs SHALL be 0.
REQ-026 Minimum latency from mX_awvalid to s_awvalid, and from mX_arvalid to s_arvalid, is one cycle (grant registration).
REQ-027 The grant SHALL NOT change until the response handshake completes; the slave sees at most one outstanding write and one outstanding read.
REQ-028 Response codes SHALL pass through unmodified; the arbiter generates no SLVERR/DECERR.

Reset
REQ-029 While areset=1: both FSMs idle, done flags 0, both round-robin pointers = m1.
REQ-030 While areset=1: every valid/ready output is 0, regardless of the clock.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction; after release, the arbiter re-arbitrates from idle and the aborted response is not delivered.

Verification
REQ-032 m0 writes 0xDEADBEEF to addr 0 alone -> s_awvalid one cycle after m0_awvalid, s_wdata=0xDEADBEEF, m0_bvalid=1, m1_bvalid=0 throughout.
REQ-033 m0 and m1 assert awvalid in the same cycle after reset -> m0 served first, then m1; repeat -> alternates m0, m1.
REQ-034 Granted master drives wvalid 3 cycles after awvalid -> s_awvalid pulses once, s_wvalid once, a single B is returned.
REQ-035 m0 writes addr 4 while m1 reads addr 0 concurrently -> both complete; m1_rdata equals the slave value for addr 0.
REQ-036 areset pulsed while in W_RESP with bready=0 -> all outputs 0 immediately; next write is granted cleanly from W_IDLE.
REQ-037 bready held low 5 cycles -> grant held and s_bready=0 for those cycles; the other master's awready stays 0.

Source files
------------

// File: rtl/axi4l_arb2.sv
// axi4l_arb2: two AXI4-Lite masters sharing one AXI4-Lite register-bank slave.
// Writes and reads are arbitrated separately, so one master may write while
// the other reads. Each path grants one master at a time and holds the grant
// until the response handshake, so the slave sees at most one outstanding
// write and one outstanding read. Ties are broken round-robin per path.
//
// Write FSM
//   state  | meaning
//   W_IDLE | no grant; waiting for any awvalid
//   W_XFER | AW and W of the granted master forwarded until both handshake
//   W_RESP | B routed back to the granted master until bvalid & bready
//
// Read FSM
//   state  | meaning
//   R_IDLE | no grant; waiting for any arvalid
//   R_XFER | AR of the granted master forwarded until it handshakes
//   R_RESP | R routed back to the granted master until rvalid & rready

module axi4l_arb2 #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,

    // master 0
    input  logic                    m0_awvalid,
    input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
    input  logic [2:0]              m0_awprot,
    output logic                    m0_awready,
    input  logic                    m0_wvalid,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    output logic                    m0_wready,
    output logic                    m0_bvalid,
    output logic [1:0]              m0_bresp,
    input  logic                    m0_bready,
    input  logic                    m0_arvalid,
    input  logic [ADDR_WIDTH-1:0]   m0_araddr,
    input  logic [2:0]              m0_arprot,
    output logic                    m0_arready,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic [1:0]              m0_rresp,
    input  logic                    m0_rready,

    // master 1
    input  logic                    m1_awvalid,
    input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic [2:0]              m1_awprot,
    output logic                    m1_awready,
    input  logic                    m1_wvalid,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic                    m1_wready,
    output logic                    m1_bvalid,
    output logic [1:0]              m1_bresp,
    input  logic                    m1_bready,
    input  logic                    m1_arvalid,
    input  logic [ADDR_WIDTH-1:0]   m1_araddr,
    input  logic [2:0]              m1_arprot,
    output logic                    m1_arready,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic [1:0]              m1_rresp,
    input  logic                    m1_rready,

    // shared slave
    output logic                    s_awvalid,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    output logic [2:0]              s_awprot,
    input  logic                    s_awready,
    output logic                    s_wvalid,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wready,
    input  logic                    s_bvalid,
    input  logic [1:0]              s_bresp,
    output logic                    s_bready,
    output logic                    s_arvalid,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    output logic [2:0]              s_arprot,
    input  logic                    s_arready,
    input  logic                    s_rvalid,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic [1:0]              s_rresp,
    output logic                    s_rready
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_XFER = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    // Grant and last-granted encode the master index: 0 = m0, 1 = m1.
    w_state_t w_state, w_state_nxt;
    logic     w_gnt, w_gnt_nxt;
    logic     w_last, w_last_nxt;
    logic     aw_done, aw_done_nxt;
    logic     w_done, w_done_nxt;
    logic     aw_hs, w_hs;

    r_state_t r_state, r_state_nxt;
    logic     r_gnt, r_gnt_nxt;
    logic     r_last, r_last_nxt;

    logic     sel_awvalid, sel_wvalid, sel_bready;
    logic     sel_arvalid, sel_rready;

    // Response payloads are broadcast; only the valid flags depend on grant.
    assign m0_bresp = s_bresp;
    assign m1_bresp = s_bresp;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m1_rresp = s_rresp;

    assign sel_awvalid = w_gnt ? m1_awvalid : m0_awvalid;
    assign sel_wvalid  = w_gnt ? m1_wvalid  : m0_wvalid;
    assign sel_bready  = w_gnt ? m1_bready  : m0_bready;
    assign sel_arvalid = r_gnt ? m1_arvalid : m0_arvalid;
    assign sel_rready  = r_gnt ? m1_rready  : m0_rready;

    // Forward the write-granted master's AW/W payload to the slave.
    always_comb begin
        if (w_gnt) begin
            s_awaddr = m1_awaddr;
            s_awprot = m1_awprot;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
        end else begin
            s_awaddr = m0_awaddr;
            s_awprot = m0_awprot;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
        end
    end

    // Forward the read-granted master's AR payload to the slave.
    always_comb begin
        if (r_gnt) begin
            s_araddr = m1_araddr;
            s_arprot = m1_arprot;
        end else begin
            s_araddr = m0_araddr;
            s_arprot = m0_arprot;
        end
    end

    // Write path state register; pointer resets to m1 so m0 wins the first tie.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_gnt   <= 1'b0;
            w_last  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            w_gnt   <= w_gnt_nxt;
            w_last  <= w_last_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    // Write path next-state and channel gating.
    always_comb begin
        w_state_nxt = w_state;
        w_gnt_nxt   = w_gnt;
        w_last_nxt  = w_last;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        s_awvalid   = 1'b0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        m0_awready  = 1'b0;
        m1_awready  = 1'b0;
        m0_wready   = 1'b0;
        m1_wready   = 1'b0;
        m0_bvalid   = 1'b0;
        m1_bvalid   = 1'b0;

        case (w_state)
            W_IDLE: begin
                if (m0_awvalid || m1_awvalid) begin
                    // On a tie the master not granted last wins.
                    w_gnt_nxt   = (m0_awvalid && m1_awvalid) ? ~w_last : m1_awvalid;
                    w_state_nxt = W_XFER;
                end
            end
            W_XFER: begin
                // Done flags keep a channel from being issued twice while
                // the other channel is still waiting for its handshake.
                s_awvalid   = sel_awvalid & ~aw_done;
                s_wvalid    = sel_wvalid & ~w_done;
                m0_awready  = ~w_gnt & ~aw_done & s_awready;
                m1_awready  =  w_gnt & ~aw_done & s_awready;
                m0_wready   = ~w_gnt & ~w_done & s_wready;
                m1_wready   =  w_gnt & ~w_done & s_wready;
                aw_hs       = s_awvalid & s_awready;
                w_hs        = s_wvalid & s_wready;
                aw_done_nxt = aw_done | aw_hs;
                w_done_nxt  = w_done | w_hs;
                if (aw_done_nxt && w_done_nxt) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                s_bready  = sel_bready;
                m0_bvalid = ~w_gnt & s_bvalid;
                m1_bvalid =  w_gnt & s_bvalid;
                if (s_bvalid && sel_bready) begin
                    w_state_nxt = W_IDLE;
                    w_last_nxt  = w_gnt;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = W_IDLE;
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // Read path state register; pointer resets to m1 so m0 wins the first tie.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= r_state_nxt;
            r_gnt   <= r_gnt_nxt;
            r_last  <= r_last_nxt;
        end
    end

    // Read path next-state and channel gating.
    always_comb begin
        r_state_nxt = r_state;
        r_gnt_nxt   = r_gnt;
        r_last_nxt  = r_last;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;

        case (r_state)
            R_IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    r_gnt_nxt   = (m0_arvalid && m1_arvalid) ? ~r_last : m1_arvalid;
                    r_state_nxt = R_XFER;
                end
            end
            R_XFER: begin
                s_arvalid  = sel_arvalid;
                m0_arready = ~r_gnt & s_arready;
                m1_arready =  r_gnt & s_arready;
                if (sel_arvalid && s_arready) begin
                    r_state_nxt = R_RESP;
                end
            end
            R_RESP: begin
                s_rready  = sel_rready;
                m0_rvalid = ~r_gnt & s_rvalid;
                m1_rvalid =  r_gnt & s_rvalid;
                if (s_rvalid && sel_rready) begin
                    r_state_nxt = R_IDLE;
                    r_last_nxt  = r_gnt;
                end
            end
            default: begin
                r_state_nxt = R_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4l_arb2.sv
// Directed bench for axi4l_arb2 with a small register-bank slave model.
module tb_axi4l_arb2;

    localparam int AW = 3;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    // master-side stimulus (index = master number)
    logic [1:0] m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [AW-1:0] m_awaddr [2];
    logic [2:0]    m_awprot [2];
    logic [31:0]   m_wdata  [2];
    logic [3:0]    m_wstrb  [2];
    logic [AW-1:0] m_araddr [2];
    logic [2:0]    m_arprot [2];

    // master-side DUT outputs
    wire [1:0]  m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    wire [1:0]  m_bresp [2];
    wire [31:0] m_rdata [2];
    wire [1:0]  m_rresp [2];

    // slave side
    wire          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    wire [AW-1:0] s_awaddr, s_araddr;
    wire [2:0]    s_awprot, s_arprot;
    wire [31:0]   s_wdata;
    wire [3:0]    s_wstrb;
    logic         s_awready = 1'b1;
    logic         s_wready  = 1'b1;
    logic         s_arready = 1'b1;
    logic         s_bvalid, s_rvalid;
    logic [1:0]   s_bresp, s_rresp;
    logic [31:0]  s_rdata;

    wire [14:0] vr = {m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                      s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};

    int n_checks = 0;
    int n_pass = 0;

    axi4l_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset),
        .m0_awvalid(m_awvalid[0]), .m0_awaddr(m_awaddr[0]), .m0_awprot(m_awprot[0]), .m0_awready(m_awready[0]),
        .m0_wvalid(m_wvalid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wready(m_wready[0]),
        .m0_bvalid(m_bvalid[0]), .m0_bresp(m_bresp[0]), .m0_bready(m_bready[0]),
        .m0_arvalid(m_arvalid[0]), .m0_araddr(m_araddr[0]), .m0_arprot(m_arprot[0]), .m0_arready(m_arready[0]),
        .m0_rvalid(m_rvalid[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rready(m_rready[0]),
        .m1_awvalid(m_awvalid[1]), .m1_awaddr(m_awaddr[1]), .m1_awprot(m_awprot[1]), .m1_awready(m_awready[1]),
        .m1_wvalid(m_wvalid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wready(m_wready[1]),
        .m1_bvalid(m_bvalid[1]), .m1_bresp(m_bresp[1]), .m1_bready(m_bready[1]),
        .m1_arvalid(m_arvalid[1]), .m1_araddr(m_araddr[1]), .m1_arprot(m_arprot[1]), .m1_arready(m_arready[1]),
        .m1_rvalid(m_rvalid[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rready(m_rready[1]),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready)
    );

    // ---------------- slave model: two 32-bit registers at 0 and 4 ----------
    logic [31:0] mem [2];
    logic [31:0] wlog [$];
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit          sl_aw_got, sl_w_got;
    logic [AW-1:0] sl_aw_addr;
    logic [31:0] sl_wdata;

    initial begin
        mem[0] = 32'h0;
        mem[1] = 32'h0;
    end

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_bvalid  <= 1'b0;
            s_rvalid  <= 1'b0;
            s_bresp   <= 2'b00;
            s_rresp   <= 2'b00;
            s_rdata   <= 32'h0;
            sl_aw_got = 1'b0;
            sl_w_got  = 1'b0;
        end else begin
            if (s_awvalid && s_awready) begin
                sl_aw_got  = 1'b1;
                sl_aw_addr = s_awaddr;
                aw_cnt++;
            end
            if (s_wvalid && s_wready) begin
                sl_w_got = 1'b1;
                sl_wdata = s_wdata;
                w_cnt++;
                wlog.push_back(s_wdata);
            end
            if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
                b_cnt++;
            end
            if (sl_aw_got && sl_w_got && !s_bvalid) begin
                mem[sl_aw_addr[2]] = sl_wdata;
                s_bvalid  <= 1'b1;
                s_bresp   <= bresp_cfg;
                sl_aw_got = 1'b0;
                sl_w_got  = 1'b0;
            end
            if (s_arvalid && s_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= mem[s_araddr[2]];
                s_rresp  <= rresp_cfg;
            end
            if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_txn(input int m, input logic [AW-1:0] addr, input logic [31:0] data,
                             input int wdelay, output bit ok, output logic [1:0] resp);
        int t = 0;
        bit done = 1'b0;
        bit aw_f, w_f;
        m_awaddr[m] = addr;
        m_awprot[m] = 3'b000;
        m_wdata[m]  = data;
        m_wstrb[m]  = 4'hF;
        m_bready[m] = 1'b1;
        m_awvalid[m] = 1'b1;
        m_wvalid[m]  = (wdelay == 0);
        resp = 2'bxx;
        while (!done && t < 60) begin
            aw_f = m_awvalid[m] & m_awready[m];
            w_f  = m_wvalid[m] & m_wready[m];
            if (m_bvalid[m]) begin
                done = 1'b1;
                resp = m_bresp[m];
            end
            tick();
            t++;
            if (aw_f) m_awvalid[m] = 1'b0;
            if (w_f) m_wvalid[m] = 1'b0;
            if (t == wdelay) m_wvalid[m] = 1'b1;
        end
        m_bready[m] = 1'b0;
        m_awvalid[m] = 1'b0;
        m_wvalid[m] = 1'b0;
        ok = done;
    endtask

    task automatic read_txn(input int m, input logic [AW-1:0] addr,
                            output bit ok, output logic [31:0] data, output logic [1:0] resp);
        int t = 0;
        bit done = 1'b0;
        bit ar_f;
        m_araddr[m] = addr;
        m_arprot[m] = 3'b000;
        m_rready[m] = 1'b1;
        m_arvalid[m] = 1'b1;
        data = 32'hx;
        resp = 2'bxx;
        while (!done && t < 60) begin
            ar_f = m_arvalid[m] & m_arready[m];
            if (m_rvalid[m]) begin
                done = 1'b1;
                data = m_rdata[m];
                resp = m_rresp[m];
            end
            tick();
            t++;
            if (ar_f) m_arvalid[m] = 1'b0;
        end
        m_rready[m] = 1'b0;
        m_arvalid[m] = 1'b0;
        ok = done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        areset = 1'b1;
        m_awvalid = 2'b11;
        m_wvalid  = 2'b11;
        m_arvalid = 2'b11;
        m_bready  = 2'b11;
        m_rready  = 2'b11;
        repeat (3) tick();
        n_checks++;
        if (vr !== 15'h0) $display("FAIL reset_outputs: got %h expected 0000", vr);
        else n_pass++;
        m_awvalid = 2'b00;
        m_wvalid  = 2'b00;
        m_arvalid = 2'b00;
        m_bready  = 2'b00;
        m_rready  = 2'b00;
        areset = 1'b0;
        tick();
        n_checks++;
        if (vr !== 15'h0) $display("FAIL idle_outputs: got %h expected 0000", vr);
        else n_pass++;
    endtask

    task automatic test_single_write();
        int t = 0;
        bit m1_seen = 1'b0;
        int aw0 = aw_cnt;
        m_awaddr[0] = 3'd0;
        m_awprot[0] = 3'b000;
        m_wdata[0]  = 32'hDEADBEEF;
        m_wstrb[0]  = 4'hF;
        m_bready[0] = 1'b1;
        m_awvalid[0] = 1'b1;
        m_wvalid[0]  = 1'b1;
        #1;
        n_checks++;
        if (s_awvalid !== 1'b0) $display("FAIL sw_lat0: s_awvalid got %b expected 0", s_awvalid);
        else n_pass++;
        tick();
        n_checks++;
        if (s_awvalid !== 1'b1) $display("FAIL sw_lat1: s_awvalid got %b expected 1", s_awvalid);
        else n_pass++;
        n_checks++;
        if (s_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h expected deadbeef", s_wdata);
        else n_pass++;
        tick();
        m_awvalid[0] = 1'b0;
        m_wvalid[0]  = 1'b0;
        while (m_bvalid[0] !== 1'b1 && t < 20) begin
            if (m_bvalid[1]) m1_seen = 1'b1;
            tick();
            t++;
        end
        n_checks++;
        if (m_bvalid[0] !== 1'b1) $display("FAIL sw_bvalid: m0_bvalid got %b expected 1", m_bvalid[0]);
        else n_pass++;
        repeat (3) begin
            if (m_bvalid[1]) m1_seen = 1'b1;
            tick();
        end
        m_bready[0] = 1'b0;
        n_checks++;
        if (m1_seen !== 1'b0) $display("FAIL sw_m1_bvalid: m1_bvalid seen got %b expected 0", m1_seen);
        else n_pass++;
        n_checks++;
        if (mem[0] !== 32'hDEADBEEF || aw_cnt - aw0 != 1)
            $display("FAIL sw_slave: mem0 got %h aw count %0d expected deadbeef 1", mem[0], aw_cnt - aw0);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok0, ok1, oks;
        logic [1:0] r0, r1, rs;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        tick();
        wlog.delete();
        fork
            write_txn(0, 3'd4, 32'hA0A0_0000, 0, ok0, r0);
            write_txn(1, 3'd4, 32'hA1A1_0001, 0, ok1, r1);
        join
        n_checks++;
        if (!(ok0 && ok1 && wlog.size() == 2 && wlog[0] == 32'hA0A0_0000 && wlog[1] == 32'hA1A1_0001))
            $display("FAIL rr_tie1: order size %0d ok %b%b expected m0 then m1", wlog.size(), ok0, ok1);
        else n_pass++;
        wlog.delete();
        fork
            write_txn(0, 3'd4, 32'hA2A2_0002, 0, ok0, r0);
            write_txn(1, 3'd4, 32'hA3A3_0003, 0, ok1, r1);
        join
        n_checks++;
        if (!(ok0 && ok1 && wlog.size() == 2 && wlog[0] == 32'hA2A2_0002 && wlog[1] == 32'hA3A3_0003))
            $display("FAIL rr_tie2: order size %0d ok %b%b expected m0 then m1", wlog.size(), ok0, ok1);
        else n_pass++;
        write_txn(0, 3'd4, 32'hB0B0_0000, 0, oks, rs);
        wlog.delete();
        fork
            write_txn(0, 3'd4, 32'hC0C0_0000, 0, ok0, r0);
            write_txn(1, 3'd4, 32'hC1C1_0001, 0, ok1, r1);
        join
        n_checks++;
        if (!(oks && ok0 && ok1 && wlog.size() == 2 && wlog[0] == 32'hC1C1_0001 && wlog[1] == 32'hC0C0_0000))
            $display("FAIL rr_after_m0: order size %0d ok %b%b%b expected m1 then m0", wlog.size(), oks, ok0, ok1);
        else n_pass++;
    endtask

    task automatic test_w_delay();
        int t = 0;
        int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt;
        // master holds AW valid until its W is accepted
        m_awaddr[1] = 3'd4;
        m_awprot[1] = 3'b000;
        m_wdata[1]  = 32'h5555AAAA;
        m_wstrb[1]  = 4'hF;
        m_bready[1] = 1'b1;
        m_awvalid[1] = 1'b1;
        repeat (3) tick();
        m_wvalid[1] = 1'b1;
        while (!(m_wvalid[1] && m_wready[1]) && t < 20) begin
            tick();
            t++;
        end
        tick();
        m_awvalid[1] = 1'b0;
        m_wvalid[1]  = 1'b0;
        t = 0;
        while (m_bvalid[1] !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        tick();
        m_bready[1] = 1'b0;
        tick();
        n_checks++;
        if (aw_cnt - aw0 != 1) $display("FAIL wd_aw_count: got %0d expected 1", aw_cnt - aw0);
        else n_pass++;
        n_checks++;
        if (w_cnt - w0 != 1) $display("FAIL wd_w_count: got %0d expected 1", w_cnt - w0);
        else n_pass++;
        n_checks++;
        if (b_cnt - b0 != 1 || mem[1] !== 32'h5555AAAA)
            $display("FAIL wd_b_count: got %0d mem1 %h expected 1 5555aaaa", b_cnt - b0, mem[1]);
        else n_pass++;
    endtask

    task automatic test_concurrent();
        bit okw, okr, ok;
        logic [1:0] rw, rr;
        logic [31:0] rd;
        write_txn(0, 3'd0, 32'h01234567, 0, ok, rw);
        fork
            write_txn(0, 3'd4, 32'hCAFEF00D, 0, okw, rw);
            read_txn(1, 3'd0, okr, rd, rr);
            begin
                tick();
                n_checks++;
                if ({s_awvalid, s_arvalid} !== 2'b11)
                    $display("FAIL cc_overlap: aw/ar valid got %b expected 11", {s_awvalid, s_arvalid});
                else n_pass++;
            end
        join
        n_checks++;
        if (!(ok && okr) || rd !== 32'h01234567)
            $display("FAIL cc_rdata: got %h ok %b%b expected 01234567", rd, ok, okr);
        else n_pass++;
        n_checks++;
        if (!okw || mem[1] !== 32'hCAFEF00D) $display("FAIL cc_write: mem1 got %h ok %b expected cafef00d", mem[1], okw);
        else n_pass++;
    endtask

    task automatic test_resp_pass();
        bit ok;
        logic [1:0] r;
        logic [31:0] rd;
        bresp_cfg = 2'b10;
        write_txn(1, 3'd0, 32'h13572468, 0, ok, r);
        bresp_cfg = 2'b00;
        n_checks++;
        if (!ok || r !== 2'b10) $display("FAIL pass_bresp: got %b ok %b expected 10", r, ok);
        else n_pass++;
        rresp_cfg = 2'b11;
        read_txn(0, 3'd0, ok, rd, r);
        rresp_cfg = 2'b00;
        n_checks++;
        if (!ok || r !== 2'b11 || rd !== 32'h13572468)
            $display("FAIL pass_rresp: got %b %h ok %b expected 11 13572468", r, rd, ok);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int t = 0;
        bit seen = 1'b0;
        bit ok, aw_f, w_f;
        logic [1:0] r;
        m_awaddr[0] = 3'd0;
        m_wdata[0]  = 32'h0BADF00D;
        m_wstrb[0]  = 4'hF;
        m_bready[0] = 1'b0;
        m_awvalid[0] = 1'b1;
        m_wvalid[0]  = 1'b1;
        while (m_bvalid[0] !== 1'b1 && t < 20) begin
            aw_f = m_awvalid[0] & m_awready[0];
            w_f  = m_wvalid[0] & m_wready[0];
            tick();
            t++;
            if (aw_f) m_awvalid[0] = 1'b0;
            if (w_f) m_wvalid[0] = 1'b0;
        end
        n_checks++;
        if (m_bvalid[0] !== 1'b1) $display("FAIL ab_wresp: m0_bvalid got %b expected 1", m_bvalid[0]);
        else n_pass++;
        tick();
        #2;
        areset = 1'b1;
        #1;
        n_checks++;
        if (vr !== 15'h0) $display("FAIL ab_async: got %h expected 0000", vr);
        else n_pass++;
        m_awvalid[0] = 1'b0;
        m_wvalid[0]  = 1'b0;
        m_bready[0]  = 1'b1;
        tick();
        areset = 1'b0;
        repeat (4) begin
            if (vr !== 15'h0) seen = 1'b1;
            tick();
        end
        m_bready[0] = 1'b0;
        n_checks++;
        if (seen !== 1'b0) $display("FAIL ab_no_resp: activity after abort got %b expected 0", seen);
        else n_pass++;
        wlog.delete();
        write_txn(1, 3'd4, 32'h77778888, 0, ok, r);
        n_checks++;
        if (!ok || wlog.size() != 1 || mem[1] !== 32'h77778888)
            $display("FAIL ab_regrant: ok %b log %0d mem1 %h expected 1 1 77778888", ok, wlog.size(), mem[1]);
        else n_pass++;
    endtask

    task automatic test_bready_hold();
        int t = 0;
        bit bad_sb = 1'b0, bad_m1 = 1'b0, bad_bv = 1'b0;
        bit ok, aw_f, w_f;
        logic [1:0] r;
        m_awaddr[0] = 3'd0;
        m_wdata[0]  = 32'h24682468;
        m_wstrb[0]  = 4'hF;
        m_bready[0] = 1'b0;
        m_awvalid[0] = 1'b1;
        m_wvalid[0]  = 1'b1;
        tick();
        m_awaddr[1] = 3'd4;
        m_wdata[1]  = 32'h99990000;
        m_wstrb[1]  = 4'hF;
        m_awvalid[1] = 1'b1;
        m_wvalid[1]  = 1'b1;
        while (m_bvalid[0] !== 1'b1 && t < 20) begin
            aw_f = m_awvalid[0] & m_awready[0];
            w_f  = m_wvalid[0] & m_wready[0];
            tick();
            t++;
            if (aw_f) m_awvalid[0] = 1'b0;
            if (w_f) m_wvalid[0] = 1'b0;
        end
        repeat (5) begin
            if (s_bready !== 1'b0) bad_sb = 1'b1;
            if (m_bvalid !== 2'b01) bad_bv = 1'b1;
            if (m_awready[1] !== 1'b0 || m_wready[1] !== 1'b0) bad_m1 = 1'b1;
            tick();
        end
        n_checks++;
        if (bad_sb !== 1'b0) $display("FAIL bh_s_bready: high seen got %b expected 0", bad_sb);
        else n_pass++;
        n_checks++;
        if (bad_bv !== 1'b0) $display("FAIL bh_bvalid_hold: bad seen got %b expected 0", bad_bv);
        else n_pass++;
        n_checks++;
        if (bad_m1 !== 1'b0) $display("FAIL bh_m1_ready: high seen got %b expected 0", bad_m1);
        else n_pass++;
        m_bready[0] = 1'b1;
        tick();
        m_bready[0] = 1'b0;
        wlog.delete();
        write_txn(1, 3'd4, 32'h99990000, 0, ok, r);
        n_checks++;
        if (!ok || mem[0] !== 32'h24682468 || mem[1] !== 32'h99990000 || wlog.size() != 1)
            $display("FAIL bh_pending: ok %b mem0 %h mem1 %h expected 1 24682468 99990000", ok, mem[0], mem[1]);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_awvalid = 2'b00;
        m_wvalid  = 2'b00;
        m_bready  = 2'b00;
        m_arvalid = 2'b00;
        m_rready  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_awaddr[i] = '0;
            m_awprot[i] = '0;
            m_wdata[i]  = '0;
            m_wstrb[i]  = '0;
            m_araddr[i] = '0;
            m_arprot[i] = '0;
        end
        test_reset();
        test_single_write();
        test_round_robin();
        test_w_delay();
        test_concurrent();
        test_resp_pass();
        test_reset_abort();
        test_bready_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
